msk_mixcolumn_stage: RTL
========================

// Module: msk_mixcolumn_stage
// PURPOSE
//  Column-serial masked AES MixColumns stage for the 32-bit datapath: accepts one masked 4-byte column per beat,
//  applies MixColumns sharewise (or bypasses it in the final round) and holds the result in a registered
//  valid/ready output. It sits between SubBytes/ShiftRows and AddRoundKey. It consumes the sharewise
//  x2/x3 products of MSKprodMC. It is purely linear: no randomness, and no cross-share mixing anywhere.
// PARAMETERS
//  d  2  number of shares (d>=2)
// PORTS
//  clk         in   1       clock
//  rst         in   1       synchronous, active-high reset
//  in_valid    in   1       input column valid
//  in_ready    out  1       stage can accept a column
//  in_bypass   in   1       1: final round, pass the column unchanged; 0: apply MixColumns
//  in_col      in   32*d    masked column; byte b = [8*d*b +: 8*d]; bit i of share j in byte b = [8*d*b + i*d + j]
//  out_valid   out  1       output column valid
//  out_ready   in   1       downstream accepts output
//  out_col     out  32*d    masked result, same share layout as in_col
//  out_idx     out  2       column index (0..3) of the presented column within the state
//  out_last    out  1       1 when out_idx==3
// BEHAVIOUR
//  - Transfer: in_valid&in_ready accepts; out_valid&out_ready retires. Inputs are sampled only on accept.
//  - MixColumns (GF(2^8), poly 0x11b), per share s, bytes a0..a3:
//      o0=2a0^3a1^a1'... precisely o0=2a0^3a1^a2^a3, o1=a0^2a1^3a2^a3, o2=a0^a1^2a2^3a3, o3=3a0^a1^a2^2a3.
//  - in_bypass=1: o_b=a_b. The flag travels with its beat, so consecutive beats may differ.
//  - Column counter col_cnt (2b): increments mod 4 on every accept; 3 wraps to 0. The beat's value is captured as out_idx.
//  - Default (single stage): latency 1; in_ready = !out_valid | out_ready (combinational on out_ready).
//    Full throughput of 1 column/cycle is sustained while out_ready=1.
//  - Stall: out_valid=1 & out_ready=0 holds out_col/out_idx/out_last stable; in_ready=0.
//  - Simultaneous retire+accept: the new column replaces the old in the same edge; out_valid stays 1.
//  - Reset (any time, including mid-state): out_valid=0, out_col=0, out_idx=0, out_last=0, col_cnt=0.
//    The partially transferred state is discarded, and the next accepted beat is column 0.
//  - in_ready is 0 during the rst cycle.
//  - Registers hold share-separated data only; no glitch-sensitive recombination.
// CONFIGURATION
//  MSKMC_PIPE_EN defined: inserts a register stage holding x2/x3 products, bypass flag and index.
//    Latency 2, still 1 column/cycle. in_ready = !s1_valid | (!out_valid | out_ready).
//    s1 advances into the output register whenever that register is empty or retiring.
//    A bubble in s1 is collapsed, and reset clears both valids.
//  MSKMC_PIPE_EN undefined: single stage as above, latency 1.
// STRUCTURE
//  - Shared package/header: MixColumns poly constant 8'h1b and MC_COLS=4.
//    It also holds the share-layout index macro (byte,bit,share)->offset, used by all 32-bit-datapath stages.
//  - Sub-module: four instances of MSKprodMC (one per byte) give sharewise 2a/3a.
//  - This module has the XOR network, bypass mux, counter and handshake/pipeline registers.
// TESTING
//  - Recombined output = XOR of shares. Each input is drawn with fresh random masks; d=2 and d=3 both run.
//  1 Column db,13,53,45 (byte0..3), bypass=0 -> recombined 8e,4d,a1,bc; out_idx=0; latency 1 (2 with _EN).
//  2 Four beats f2,0a,22,5c / 01,01,01,01 / c6,c6,c6,c6 / d4,d4,d4,d5 back-to-back.
//    -> 9f,dc,58,9d / 01,01,01,01 / c6,c6,c6,c6 / d5,d5,d7,d6; out_idx 0..3; out_last only on beat 4;
//       counter wraps to 0 for the fifth beat.
//  3 bypass=1 with db,13,53,45 -> each share is output bit-identical to its input; out_idx still increments.
//  4 Hold out_ready=0 for 5 cycles with in_valid=1: out_col stable, in_ready=0.
//    Release: no loss or duplication; 8-beat random stream matches the golden model.
//  5 Assert rst after 2 accepted columns: out_valid=0 next cycle, out_col=0, next accepted beat reports out_idx=0.
//  6 Share independence: fix share0 and randomize share1 -> share0 of the output matches the per-share model
//    and is independent of share1.

Source files
------------

// File: rtl/msk_mixcolumn_stage_pkg.sv
// Shared constants for the masked 32-bit AES datapath stages.
// Share layout: bit i of share j in byte b sits at offset 8*d*b + i*d + j.
package msk_mixcolumn_stage_pkg;

   localparam logic [7:0] MC_POLY = 8'h1b;  // x^8 reduction term of 0x11b
   localparam int         MC_COLS = 4;      // bytes per column / columns per state

   // (byte, bit, share) -> flat offset into a masked column vector.
   function automatic int msk_off(input int b, input int i, input int j, input int d);
      return 8*d*b + i*d + j;
   endfunction

endpackage

// File: rtl/msk_mixcolumn_stage_prod.sv
// MSKprodMC: sharewise 2a and 3a of one masked byte.
// xtime is GF(2)-linear, so each share is processed on its own; shares never mix.
module msk_mixcolumn_stage_prod
   import msk_mixcolumn_stage_pkg::*;
#(
   parameter int d = 2
) (
   input  logic [8*d-1:0] a,
   output logic [8*d-1:0] x2,
   output logic [8*d-1:0] x3
);

   logic [d-1:0][7:0] s;
   logic [d-1:0][7:0] t;

   for (genvar j = 0; j < d; j++) begin : g_sh
      for (genvar i = 0; i < 8; i++) begin : g_bit
         assign s[j][i]                 = a[msk_off(0, i, j, d)];
         assign x2[msk_off(0, i, j, d)] = t[j][i];
         assign x3[msk_off(0, i, j, d)] = t[j][i] ^ s[j][i];
      end
      assign t[j] = {s[j][6:0], 1'b0} ^ (s[j][7] ? MC_POLY : 8'h00);
   end

endmodule

// File: rtl/msk_mixcolumn_stage.sv
// Column-serial masked MixColumns stage with a registered valid/ready output.
// Define MSKMC_PIPE_EN to add a product register stage (latency 2 instead of 1).
// Because the layout interleaves shares bit by bit and XOR is bitwise, the
// XOR network runs on whole masked bytes without ever combining shares.
module msk_mixcolumn_stage
   import msk_mixcolumn_stage_pkg::*;
#(
   parameter int d = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_bypass,
   input  logic [32*d-1:0] in_col,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [32*d-1:0] out_col,
   output logic [1:0]      out_idx,
   output logic            out_last
);

   localparam int W = 8*d;

   logic [MC_COLS-1:0][W-1:0] a_in, x2_in, x3_in;
   logic [MC_COLS-1:0][W-1:0] m_a, m_x2, m_x3, mix;
   logic                      m_byp, ld_valid, accept, out_adv;
   logic [1:0]                m_idx, col_cnt;

   assign a_in = in_col;

   for (genvar b = 0; b < MC_COLS; b++) begin : g_prod
      msk_mixcolumn_stage_prod #(.d(d)) u_prod (
         .a  (a_in[b]),
         .x2 (x2_in[b]),
         .x3 (x3_in[b])
      );
   end

   // Output register can take new data when empty or retiring this edge.
   assign out_adv = !out_valid | out_ready;
   assign accept  = in_valid & in_ready;

`ifdef MSKMC_PIPE_EN
   logic                      s1_valid, s1_byp;
   logic [1:0]                s1_idx;
   logic [MC_COLS-1:0][W-1:0] s1_a, s1_x2, s1_x3;

   assign in_ready = !rst & (!s1_valid | out_adv);

   // Product stage: refills whenever it is empty or draining into the output.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_byp   <= 1'b0;
         s1_idx   <= '0;
         s1_a     <= '0;
         s1_x2    <= '0;
         s1_x3    <= '0;
      end else if (!s1_valid | out_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_byp <= in_bypass;
            s1_idx <= col_cnt;
            s1_a   <= a_in;
            s1_x2  <= x2_in;
            s1_x3  <= x3_in;
         end
      end
   end

   assign ld_valid = s1_valid;
   assign m_byp    = s1_byp;
   assign m_idx    = s1_idx;
   assign m_a      = s1_a;
   assign m_x2     = s1_x2;
   assign m_x3     = s1_x3;
`else
   assign in_ready = !rst & out_adv;
   assign ld_valid = accept;
   assign m_byp    = in_bypass;
   assign m_idx    = col_cnt;
   assign m_a      = a_in;
   assign m_x2     = x2_in;
   assign m_x3     = x3_in;
`endif

   // Column position within the state, advanced on every accepted beat.
   always_ff @(posedge clk) begin
      if (rst)         col_cnt <= '0;
      else if (accept) col_cnt <= col_cnt + 2'd1;
   end

   // Sharewise MixColumns XOR network, or pass-through in the final round.
   always_comb begin
      mix[0] = m_x2[0] ^ m_x3[1] ^ m_a[2]  ^ m_a[3];
      mix[1] = m_a[0]  ^ m_x2[1] ^ m_x3[2] ^ m_a[3];
      mix[2] = m_a[0]  ^ m_a[1]  ^ m_x2[2] ^ m_x3[3];
      mix[3] = m_x3[0] ^ m_a[1]  ^ m_a[2]  ^ m_x2[3];
      if (m_byp) mix = m_a;
   end

   // Output register: holds under stall, swaps in the next column on retire.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_col   <= '0;
         out_idx   <= '0;
      end else if (out_adv) begin
         out_valid <= ld_valid;
         if (ld_valid) begin
            out_col <= mix;
            out_idx <= m_idx;
         end
      end
   end

   assign out_last = (out_idx == 2'd3);

endmodule
